// File: rtl/ddr3_port_responder.sv
// rtl/ddr3_port_responder.sv - MCB-style user-port memory responder backed by an internal word RAM
// Optional byte-mask write support: define DDR3_RESP_MASK_EN
module ddr3_port_responder #(
    parameter int MEM_AW         = 10,
    parameter int CMD_DEPTH_LOG2 = 2,
    parameter int RD_LATENCY     = 4,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_en,
    input  logic [2:0]  cmd_instr,
    input  logic [5:0]  cmd_bl,
    input  logic [27:0] cmd_word_addr,
    output logic        cmd_empty,
    output logic        cmd_full,
    input  logic        wr_en,
    input  logic [3:0]  wr_mask,
    input  logic [31:0] wr_data,
    output logic        wr_full,
    output logic        wr_empty,
    output logic [6:0]  wr_count,
    output logic        wr_underrun,
    output logic        wr_error,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_full,
    output logic        rd_empty,
    output logic [6:0]  rd_count,
    output logic        rd_overflow,
    output logic        rd_error
);
    localparam int CMD_DEPTH = 1 << CMD_DEPTH_LOG2;
    localparam int CMD_W     = 3 + 6 + MEM_AW;
    localparam int CNT_W     = 16;
    localparam logic [CMD_DEPTH_LOG2:0] CMD_FULL_CNT = CMD_DEPTH[CMD_DEPTH_LOG2:0];
`ifdef DDR3_RESP_MASK_EN
    localparam int WF_W = 36;
`else
    localparam int WF_W = 32;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_WRITE, S_READ_WAIT, S_READ, S_REFRESH
    } state_t;

    state_t             state_q;
    logic [2:0]         instr_q;
    logic [MEM_AW-1:0]  addr_q;
    logic [5:0]         bl_q;
    logic [5:0]         n_q;
    logic [CNT_W-1:0]   cnt_q;

    // ---------------- command FIFO ----------------
    logic [CMD_W-1:0]          cmd_mem [CMD_DEPTH];
    logic [CMD_DEPTH_LOG2-1:0] cmd_wp_q, cmd_rp_q;
    logic [CMD_DEPTH_LOG2:0]   cmd_cnt_q;
    logic                      cmd_push, cmd_pop;
    logic [CMD_W-1:0]          cmd_head;

    assign cmd_full  = (cmd_cnt_q == CMD_FULL_CNT);
    assign cmd_empty = (cmd_cnt_q == '0);
    assign cmd_push  = cmd_en && !cmd_full;
    assign cmd_pop   = (state_q == S_IDLE) && !cmd_empty;
    assign cmd_head  = cmd_mem[cmd_rp_q];

    // Command storage; only the RAM-relevant address bits are kept
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wp_q] <= {cmd_instr, cmd_bl, cmd_word_addr[MEM_AW-1:0]};
    end

    // Command FIFO pointers and occupancy; a push while full is silently dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wp_q  <= '0;
            cmd_rp_q  <= '0;
            cmd_cnt_q <= '0;
        end else begin
            if (cmd_push) cmd_wp_q <= cmd_wp_q + 1'b1;
            if (cmd_pop)  cmd_rp_q <= cmd_rp_q + 1'b1;
            case ({cmd_push, cmd_pop})
                2'b10:   cmd_cnt_q <= cmd_cnt_q + 1'b1;
                2'b01:   cmd_cnt_q <= cmd_cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- write FIFO ----------------
    logic [WF_W-1:0] wf_mem [64];
    logic [5:0]      wf_wp_q, wf_rp_q;
    logic [6:0]      wf_cnt_q;
    logic            wf_push, wf_pop;
    logic [WF_W-1:0] wf_head;

    assign wr_full     = (wf_cnt_q == 7'd64);
    assign wr_empty    = (wf_cnt_q == 7'd0);
    assign wr_count    = wf_cnt_q;
    assign wf_push     = wr_en && !wr_full;
    assign wf_pop      = (state_q == S_WRITE) && !wr_empty;
    assign wf_head     = wf_mem[wf_rp_q];
    assign wr_underrun = (state_q == S_WRITE) && wr_empty;

    // Write-data storage, with the byte mask alongside when masking is built in
    always_ff @(posedge clk) begin
`ifdef DDR3_RESP_MASK_EN
        if (wf_push) wf_mem[wf_wp_q] <= {wr_mask, wr_data};
`else
        if (wf_push) wf_mem[wf_wp_q] <= wr_data;
`endif
    end

    // Write FIFO pointers, occupancy and sticky overflow-push flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wf_wp_q  <= '0;
            wf_rp_q  <= '0;
            wf_cnt_q <= '0;
            wr_error <= 1'b0;
        end else begin
            if (wf_push) wf_wp_q <= wf_wp_q + 1'b1;
            if (wf_pop)  wf_rp_q <= wf_rp_q + 1'b1;
            if (wr_en && wr_full) wr_error <= 1'b1;
            case ({wf_push, wf_pop})
                2'b10:   wf_cnt_q <= wf_cnt_q + 1'b1;
                2'b01:   wf_cnt_q <= wf_cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- read FIFO ----------------
    logic [31:0] rf_mem [64];
    logic [5:0]  rf_wp_q, rf_rp_q;
    logic [6:0]  rf_cnt_q;
    logic [31:0] hold_q;
    logic [31:0] rdata_q;
    logic        rf_push_req, rf_push, rf_pop;

    assign rd_full     = (rf_cnt_q == 7'd64);
    assign rd_empty    = (rf_cnt_q == 7'd0);
    assign rd_count    = rf_cnt_q;
    assign rf_push_req = (state_q == S_READ);
    assign rf_push     = rf_push_req && !rd_full;
    assign rf_pop      = rd_en && !rd_empty;
    // Fall-through head; once drained the last popped word stays visible
    assign rd_data     = rd_empty ? hold_q : rf_mem[rf_rp_q];

    // Read-data storage
    always_ff @(posedge clk) begin
        if (rf_push) rf_mem[rf_wp_q] <= rdata_q;
    end

    // Read FIFO pointers, occupancy, held output word and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wp_q     <= '0;
            rf_rp_q     <= '0;
            rf_cnt_q    <= '0;
            hold_q      <= '0;
            rd_overflow <= 1'b0;
            rd_error    <= 1'b0;
        end else begin
            if (rf_push) rf_wp_q <= rf_wp_q + 1'b1;
            if (rf_pop) begin
                rf_rp_q <= rf_rp_q + 1'b1;
                hold_q  <= rf_mem[rf_rp_q];
            end
            if (rf_push_req && rd_full) rd_overflow <= 1'b1;
            if (rd_en && rd_empty)      rd_error    <= 1'b1;
            case ({rf_push, rf_pop})
                2'b10:   rf_cnt_q <= rf_cnt_q + 1'b1;
                2'b01:   rf_cnt_q <= rf_cnt_q - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- backing RAM ----------------
    logic [31:0]       mem [1 << MEM_AW];
    logic [MEM_AW-1:0] beat_addr, ram_raddr;
    logic              ram_re;

    assign beat_addr = addr_q + MEM_AW'(n_q);
    // DECODE fetches beat 0; each READ cycle fetches the beat after the one being pushed
    assign ram_raddr = (state_q == S_READ) ? beat_addr + 1'b1 : beat_addr;
    assign ram_re    = (state_q == S_DECODE) || (state_q == S_READ);

    // Synchronous RAM: write port driven by the write engine, registered read port
    always_ff @(posedge clk) begin
        if (wf_pop) begin
`ifdef DDR3_RESP_MASK_EN
            for (int b = 0; b < 4; b++) begin
                if (!wf_head[32+b]) mem[beat_addr][8*b +: 8] <= wf_head[8*b +: 8];
            end
`else
            mem[beat_addr] <= wf_head;
`endif
        end
        if (ram_re) rdata_q <= mem[ram_raddr];
    end

    // ---------------- command engine ----------------
    // Sequencer: one command at a time, fetch -> decode -> execute -> idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            addr_q  <= '0;
            bl_q    <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!cmd_empty) begin
                        instr_q <= cmd_head[CMD_W-1 -: 3];
                        bl_q    <= cmd_head[MEM_AW +: 6];
                        addr_q  <= cmd_head[MEM_AW-1:0];
                        n_q     <= '0;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (instr_q)
                        3'b000, 3'b010: state_q <= S_WRITE;
                        3'b001, 3'b011: begin
                            cnt_q   <= CNT_W'(RD_LATENCY - 1);
                            // Beat 0 is already being fetched, so a latency of 1 needs no wait
                            state_q <= (RD_LATENCY <= 1) ? S_READ : S_READ_WAIT;
                        end
                        3'b100: begin
                            cnt_q   <= CNT_W'(REFRESH_CYCLES - 1);
                            state_q <= S_REFRESH;
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
                S_WRITE: begin
                    if (!wr_empty) begin
                        n_q <= n_q + 1'b1;
                        if (n_q == bl_q) state_q <= S_IDLE;
                    end
                end
                S_READ_WAIT: begin
                    // Leaves one count early because DECODE already spent a cycle fetching beat 0
                    if (cnt_q <= CNT_W'(1)) state_q <= S_READ;
                    else                    cnt_q   <= cnt_q - 1'b1;
                end
                S_READ: begin
                    n_q <= n_q + 1'b1;
                    if (n_q == bl_q) state_q <= S_IDLE;
                end
                S_REFRESH: begin
                    if (cnt_q == '0) state_q <= S_IDLE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic unused_bits;
`ifdef DDR3_RESP_MASK_EN
    assign unused_bits = ^cmd_word_addr[27:MEM_AW];
`else
    assign unused_bits = ^{cmd_word_addr[27:MEM_AW], wr_mask};
`endif

endmodule

// File: doc/ddr3_port_responder.md
Name: ddr3_port_responder

Overview:
- Memory-side responder for one MCB-style user port (command, write-data and read-data FIFOs).
- Accepts the command/write/read traffic that the DDR3 front-end controller issues, and executes it against an internal word-addressed RAM.
- Used as a drop-in DDR3 substitute on boards without external memory, and as the bench-side memory for controller regressions.

Parameters:
- MEM_AW, 10: backing RAM address width in 32-bit words; addresses wrap modulo 2^MEM_AW.
- CMD_DEPTH_LOG2, 2: command FIFO depth is 2^CMD_DEPTH_LOG2 entries.
- RD_LATENCY, 4: cycles from read-command start to the first word pushed into the read FIFO (minimum 1).
- REFRESH_CYCLES, 8: busy cycles consumed by a refresh command.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-high.
- cmd_en  in  1  push command; ignored when cmd_full.
- cmd_instr  in  3  instruction code: 000 write, 001 read, 010 write-PC, 011 read-PC, 100 refresh.
- cmd_bl  in  6  burst length minus 1 (1..64 words).
- cmd_word_addr  in  28  start word address; only [MEM_AW-1:0] used.
- cmd_empty  out  1  command FIFO empty.
- cmd_full  out  1  command FIFO full.
- wr_en  in  1  push write word.
- wr_mask  in  4  byte mask; 1 = byte not written.
- wr_data  in  32  write word.
- wr_full  out  1  write FIFO holds 64 words.
- wr_empty  out  1  write FIFO empty.
- wr_count  out  7  write FIFO occupancy, 0..64.
- wr_underrun  out  1  write engine stalled on empty write FIFO.
- wr_error  out  1  push attempted while full (sticky).
- rd_en  in  1  pop read word.
- rd_data  out  32  head of read FIFO (first-word-fall-through).
- rd_full  out  1  read FIFO holds 64 words.
- rd_empty  out  1  read FIFO empty.
- rd_count  out  7  read FIFO occupancy, 0..64.
- rd_overflow  out  1  read word dropped because FIFO was full (sticky).
- rd_error  out  1  pop attempted while empty (sticky).

Behaviour:
- Reset:
  - All FIFOs empty: cmd_empty=1, wr_empty=1, rd_empty=1.
  - cmd_full, wr_full, rd_full = 0; wr_count = rd_count = 0; rd_data = 0.
  - All error/underrun flags = 0; state = IDLE.
  - RAM contents are not cleared.
  - Reset mid-burst aborts the burst immediately; words already written stay in RAM.
- FIFOs:
  - Push and pop in the same cycle leave the count unchanged.
  - A push while full is dropped: wr_error sets for write-FIFO pushes; a dropped cmd_en sets no flag.
  - A pop while empty is ignored, rd_data holds its value, and rd_error sets.
  - Counts and full/empty flags update the cycle after the push/pop.
  - rd_data is valid whenever rd_empty=0.
- State machine:
  - IDLE: if the command FIFO is not empty, pop the head, latch instr, addr and bl, load beat counter n = 0, then go to DECODE.
  - DECODE, by instruction:
    - 000/010 → WRITE.
    - 001/011 → READ_WAIT, loading a latency counter with RD_LATENCY-1.
    - 100 → REFRESH, loading a counter with REFRESH_CYCLES-1.
    - Any other code → IDLE; the command is discarded.
  - WRITE: each cycle with the write FIFO non-empty:
    - pop one word and write it to RAM[(addr+n) mod 2^MEM_AW];
    - n++; after beat bl (n == bl), go to IDLE.
    - If the write FIFO is empty, stall with wr_underrun=1 (level, combinational from state & wr_empty).
  - READ_WAIT: count down; at 0 go to READ.
  - READ: each cycle, push RAM[(addr+n) mod 2^MEM_AW] into the read FIFO, n++; after beat bl go to IDLE.
    - RAM is synchronous read; the engine pipelines it so one word per cycle is sustained.
    - The first push occurs exactly RD_LATENCY cycles after DECODE.
    - If the read FIFO is full at push time, the word is dropped, rd_overflow sets, and the burst continues (no stall).
  - REFRESH: count down, then go to IDLE; no RAM access.
- Ordering and timing:
  - Commands execute strictly in order; there is no overlap between commands.
  - Command-to-command turnaround is 2 cycles (IDLE, DECODE).
  - A write command whose data arrives later is legal: the engine stalls until the data arrives.
  - Sticky flags clear only on reset.

Optional Feature:
- DDR3_RESP_MASK_EN defined:
  - wr_mask is stored alongside each write word.
  - Masked bytes (mask bit 1) leave the RAM byte unchanged; RAM uses byte-write enables.
- DDR3_RESP_MASK_EN not defined:
  - wr_mask is ignored and every write updates all 4 bytes.
  - The mask is not stored, and the write FIFO is 32 bits wide.

Test Plan:
- Write then read back:
  - Push 4 words 0xA0..0xA3 via wr_en, then cmd write-PC (010), addr 0x10, bl=3.
  - Then cmd read-PC (011), addr 0x10, bl=3.
  - Required: rd_count reaches 4, first push RD_LATENCY=4 cycles after DECODE, pops return 0xA0,0xA1,0xA2,0xA3.
- Full burst with address wrap:
  - bl=63 write at addr 0x3E0 (MEM_AW=10) of 64 incrementing words.
  - Read back at 0x3E0: data matches.
  - Read at 0x000 with bl=31: returns words 32..63 of the burst.
- Read overflow:
  - Preload the read FIFO to 62 words with no pops, then issue a read with bl=3.
  - Required: rd_count=64, rd_full=1, rd_overflow=1, 2 words dropped.
- Write underrun and command FIFO full:
  - Issue a write with bl=7 with only 3 words queued: wr_underrun=1 after 3 beats.
  - Add 5 words: burst completes and wr_underrun returns to 0.
  - 5 back-to-back cmd_en pulses while the engine is blocked: cmd_full=1 after 4, the 5th command is dropped.
- Reset mid-read:
  - Assert rst during beat 10 of a 32-beat read.
  - Required: all FIFOs empty, flags 0, state IDLE immediately (asynchronous).
  - A subsequent read returns the intact RAM data.
- Byte mask, with DDR3_RESP_MASK_EN defined:
  - Write 0xFFFFFFFF to addr 5.
  - Write 0x12345678 to addr 5 with mask 4'b0101.
  - Read addr 5: returns 0x12FF56FF.
